// File: rtl/vga_pixel_fetch_if.sv
// vga_pixel_fetch_if
//   Bundles every signal between the pixel fetch block and its surroundings
//   (timing generator, framebuffer RAM, palette host, VGA pins).
//
//   Signals:
//     h_count, v_count    timing generator pixel counters
//     hsync_in, vsync_in  raw syncs, active low
//     fb_addr, fb_rd_en   framebuffer read request
//     fb_data             framebuffer read data, one cycle after the request
//     pal_we, pal_addr,   palette write port, value is {R,G,B} 4 bits each
//     pal_data
//     hsync, vsync        delayed syncs, aligned with colour
//     red, green, blue    pixel colour
//     frame_pulse         one-cycle marker on the first pixel of each frame
//
//   Modports:
//     master  the environment: drives counters, syncs, RAM data, palette writes
//     slave   the pixel fetch block itself
interface vga_pixel_fetch_if #(
    parameter int ADDR_W = 17,
    parameter int IDX_W  = 4
);
    logic [9:0]        h_count;
    logic [9:0]        v_count;
    logic              hsync_in;
    logic              vsync_in;
    logic [ADDR_W-1:0] fb_addr;
    logic              fb_rd_en;
    logic [IDX_W-1:0]  fb_data;
    logic              pal_we;
    logic [IDX_W-1:0]  pal_addr;
    logic [11:0]       pal_data;
    logic              hsync;
    logic              vsync;
    logic [3:0]        red;
    logic [3:0]        green;
    logic [3:0]        blue;
    logic              frame_pulse;

    modport master (
        output h_count, v_count, hsync_in, vsync_in, fb_data,
        output pal_we, pal_addr, pal_data,
        input  fb_addr, fb_rd_en, hsync, vsync, red, green, blue, frame_pulse
    );

    modport slave (
        input  h_count, v_count, hsync_in, vsync_in, fb_data,
        input  pal_we, pal_addr, pal_data,
        output fb_addr, fb_rd_en, hsync, vsync, red, green, blue, frame_pulse
    );
endinterface

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch
//   Turns timing generator counters into framebuffer read addresses, maps the
//   returned palette index through a 16-entry host-writable palette to 12-bit
//   RGB, and delays the syncs so they leave aligned with the colour.
//   Counter input to colour output is three clock edges.
//
//   Ports:
//     clk    pixel clock
//     reset  asynchronous, active-high reset
//     bus    vga_pixel_fetch_if.slave (counters, syncs, RAM read port,
//            palette write port, colour/sync/frame_pulse outputs)
module vga_pixel_fetch #(
    parameter int H_DISPLAY = 320,
    parameter int V_DISPLAY = 240,
    parameter int ADDR_W    = 17,
    parameter int IDX_W     = 4
) (
    input logic              clk,
    input logic              reset,
    vga_pixel_fetch_if.slave bus
);
    localparam int                PAL_N    = 2 ** IDX_W;
    localparam logic [9:0]        H_LIM    = 10'(H_DISPLAY);
    localparam logic [9:0]        V_LIM    = 10'(V_DISPLAY);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_DISPLAY);

    logic [9:0]        v_prev;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] row_cur;
    logic              active_in;

    logic [ADDR_W-1:0] addr_p0;
    logic              vld_p0;
    logic              hs_p0;
    logic              vs_p0;
    logic              sof_p0;

    logic [IDX_W-1:0]  idx_p1;
    logic              vld_p1;
    logic              hs_p1;
    logic              vs_p1;
    logic              sof_p1;

    logic [11:0]       rgb_p2;
    logic              hs_p2;
    logic              vs_p2;
    logic              sof_p2;

    logic [11:0]       pal_mem [PAL_N];

    // Row base for the line currently on the counters. It restarts at the top
    // of the frame and steps by one line width whenever v_count moves to a new
    // active line, so the address needs only an adder.
    always_comb begin
        active_in = (bus.h_count < H_LIM) && (bus.v_count < V_LIM);
        row_cur   = row_base;
        if (bus.v_count == '0) begin
            row_cur = '0;
        end else if ((bus.v_count != v_prev) && (bus.v_count < V_LIM)) begin
            row_cur = row_base + ROW_STEP;
        end
    end

    // ---- stage 0: counters -> framebuffer request ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_prev   <= '0;
            row_base <= '0;
            addr_p0  <= '0;
            vld_p0   <= 1'b0;
            hs_p0    <= 1'b1;
            vs_p0    <= 1'b1;
            sof_p0   <= 1'b0;
        end else begin
            v_prev   <= bus.v_count;
            row_base <= row_cur;
            if (active_in) begin
                addr_p0 <= row_cur + ADDR_W'(bus.h_count);
            end
            vld_p0   <= active_in;
            hs_p0    <= bus.hsync_in;
            vs_p0    <= bus.vsync_in;
            sof_p0   <= (bus.h_count == '0) && (bus.v_count == '0);
        end
    end

    // ---- stage 1: RAM data captured ----
    always_ff @(posedge clk) begin
        idx_p1 <= bus.fb_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            hs_p1  <= 1'b1;
            vs_p1  <= 1'b1;
            sof_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            hs_p1  <= hs_p0;
            vs_p1  <= vs_p0;
            sof_p1 <= sof_p0;
        end
    end

    // ---- stage 2: palette lookup -> pins ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_p2 <= '0;
            hs_p2  <= 1'b1;
            vs_p2  <= 1'b1;
            sof_p2 <= 1'b0;
        end else begin
            rgb_p2 <= vld_p1 ? pal_mem[idx_p1] : 12'h000;
            hs_p2  <= hs_p1;
            vs_p2  <= vs_p1;
            sof_p2 <= sof_p1;
        end
    end

    // Palette writes land on the same edge as a lookup; the lookup above reads
    // the pre-edge contents, so a colliding write shows from the next pixel on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PAL_N; i++) begin
                pal_mem[i] <= {4'(i), 4'(i), 4'(i)};
            end
        end else if (bus.pal_we) begin
            pal_mem[bus.pal_addr] <= bus.pal_data;
        end
    end

    assign bus.fb_addr     = addr_p0;
    assign bus.fb_rd_en    = vld_p0;
    assign bus.hsync       = hs_p2;
    assign bus.vsync       = vs_p2;
    assign bus.red         = rgb_p2[11:8];
    assign bus.green       = rgb_p2[7:4];
    assign bus.blue        = rgb_p2[3:0];
    assign bus.frame_pulse = sof_p2;
endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb_vga_pixel_fetch
//   Self-checking bench for vga_pixel_fetch. A behavioural model computes each
//   pixel's address as v*320+h, keeps a palette array and a short history of
//   sampled pixels, and predicts every output after every clock edge.
//   The RAM is modelled as fb_data = fb_addr[3:0] + ram_ofs.
module tb_vga_pixel_fetch;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] ram_ofs;
    int         n_checks = 0;
    int         n_fail   = 0;

    vga_pixel_fetch_if #(.ADDR_W(17), .IDX_W(4)) bus ();

    vga_pixel_fetch #(
        .H_DISPLAY(320),
        .V_DISPLAY(240),
        .ADDR_W(17),
        .IDX_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.fb_data = bus.fb_addr[3:0] + ram_ofs;

    typedef struct {
        bit         act;
        int         addr;
        bit         hs;
        bit         vs;
        bit         sof;
        logic [3:0] idx;
    } pix_t;

    pix_t        hist0;
    pix_t        hist1;
    int          e_addr;
    bit          e_rd;
    bit          e_hs;
    bit          e_vs;
    bit          e_fp;
    logic [11:0] e_rgb;
    logic [11:0] pal_m [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist0  = '{act: 1'b0, addr: 0, hs: 1'b1, vs: 1'b1, sof: 1'b0, idx: 4'h0};
        hist1  = hist0;
        e_addr = 0;
        e_rd   = 1'b0;
        e_hs   = 1'b1;
        e_vs   = 1'b1;
        e_fp   = 1'b0;
        e_rgb  = 12'h000;
        for (int i = 0; i < 16; i++) pal_m[i] = {4'(i), 4'(i), 4'(i)};
    endtask

    // Called right after a rising edge: predicts the outputs for that edge.
    task automatic model_edge();
        pix_t cur;
        cur.act  = (int'(bus.h_count) < 320) && (int'(bus.v_count) < 240);
        cur.addr = int'(bus.v_count) * 320 + int'(bus.h_count);
        cur.hs   = bus.hsync_in;
        cur.vs   = bus.vsync_in;
        cur.sof  = (bus.h_count == 10'd0) && (bus.v_count == 10'd0);
        cur.idx  = 4'h0;
        // RAM answers the previous edge's request at this edge
        hist0.idx = 4'((hist0.addr % 16) + int'(ram_ofs));
        if (cur.act) e_addr = cur.addr;
        e_rd  = cur.act;
        e_hs  = hist1.hs;
        e_vs  = hist1.vs;
        e_fp  = hist1.sof;
        e_rgb = hist1.act ? pal_m[hist1.idx] : 12'h000;
        if (bus.pal_we) pal_m[bus.pal_addr] = bus.pal_data;
        hist1 = hist0;
        hist0 = cur;
    endtask

    task automatic compare_all();
        check("fb_addr",     32'(bus.fb_addr),                      32'(e_addr));
        check("fb_rd_en",    32'(bus.fb_rd_en),                     32'(e_rd));
        check("hsync",       32'(bus.hsync),                        32'(e_hs));
        check("vsync",       32'(bus.vsync),                        32'(e_vs));
        check("rgb",         32'({bus.red, bus.green, bus.blue}),   32'(e_rgb));
        check("frame_pulse", 32'(bus.frame_pulse),                  32'(e_fp));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic set_px(input int h, input int v);
        bus.h_count = 10'(h);
        bus.v_count = 10'(v);
    endtask

    task automatic rand_side();
        bus.pal_we   = ($urandom_range(0, 63) == 0);
        bus.pal_addr = 4'($urandom_range(0, 15));
        bus.pal_data = 12'($urandom);
        if ($urandom_range(0, 7) == 0)  bus.hsync_in = ~bus.hsync_in;
        if ($urandom_range(0, 31) == 0) bus.vsync_in = ~bus.vsync_in;
    endtask

    initial begin
        reset        = 1'b1;
        bus.h_count  = 10'd0;
        bus.v_count  = 10'd0;
        bus.hsync_in = 1'b1;
        bus.vsync_in = 1'b1;
        bus.pal_we   = 1'b0;
        bus.pal_addr = 4'h0;
        bus.pal_data = 12'h000;
        ram_ofs      = 4'd5;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;

        // Release with counters at (0,0), RAM returns index 5
        step();
        check("t1_addr", 32'(bus.fb_addr), 32'd0);
        check("t1_rd",   32'(bus.fb_rd_en), 32'd1);
        set_px(1, 0); step();
        set_px(2, 0); step();
        check("t1_rgb",   32'({bus.red, bus.green, bus.blue}), 32'h555);
        check("t1_frame", 32'(bus.frame_pulse), 32'd1);

        // Active-region edges
        set_px(320, 0); step();
        check("t6_rd_h320", 32'(bus.fb_rd_en), 32'd0);
        set_px(0, 240); step();
        check("t6_rd_v240", 32'(bus.fb_rd_en), 32'd0);
        set_px(319, 0); step();
        check("t6_rd_319",   32'(bus.fb_rd_en), 32'd1);
        check("t6_addr_319", 32'(bus.fb_addr), 32'd319);
        check("t6_rgb_h320", 32'({bus.red, bus.green, bus.blue}), 32'h000);
        set_px(400, 0); step();
        check("t6_rgb_v240", 32'({bus.red, bus.green, bus.blue}), 32'h000);

        // Palette write colliding with a lookup of the same entry
        ram_ofs = 4'd3;
        set_px(0, 0);  step();
        set_px(16, 0); step();
        set_px(32, 0);
        bus.pal_we = 1'b1; bus.pal_addr = 4'd3; bus.pal_data = 12'hF00;
        step();
        bus.pal_we = 1'b0;
        check("t3_old", 32'({bus.red, bus.green, bus.blue}), 32'h333);
        set_px(48, 0); step();
        check("t3_new", 32'({bus.red, bus.green, bus.blue}), 32'hF00);

        // Run down to line 100, then reset asynchronously mid-cycle
        for (int v = 1; v <= 100; v++) begin
            set_px(0, v); step();
            set_px(7, v); step();
        end
        #2;
        reset = 1'b1;
        #1;
        check("t5_addr", 32'(bus.fb_addr), 32'd0);
        check("t5_rd",   32'(bus.fb_rd_en), 32'd0);
        check("t5_hs",   32'(bus.hsync), 32'd1);
        check("t5_vs",   32'(bus.vsync), 32'd1);
        check("t5_rgb",  32'({bus.red, bus.green, bus.blue}), 32'h000);
        check("t5_fp",   32'(bus.frame_pulse), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        set_px(0, 0);
        reset = 1'b0;
        step();
        set_px(16, 0); step();
        set_px(32, 0); step();
        check("t5_pal3", 32'({bus.red, bus.green, bus.blue}), 32'h333);

        // Full-frame sweep with random palette writes and sync activity
        ram_ofs = 4'($urandom);
        for (int v = 0; v < 245; v++) begin
            if (v < 240) begin
                for (int h = 0; h < 320; h++) begin
                    set_px(h, v); rand_side(); step();
                    if (v == 239 && h == 319) check("last_addr", 32'(bus.fb_addr), 32'd76799);
                end
                set_px($urandom_range(320, 1023), v); rand_side(); step();
            end else begin
                for (int k = 0; k < 3; k++) begin
                    set_px($urandom_range(0, 1023), v); rand_side(); step();
                end
            end
        end

        // Random horizontal positions, including blanking lines and out-of-range counters
        for (int v = 0; v < 260; v++) begin
            for (int k = 0; k < 4; k++) begin
                set_px($urandom_range(0, 399), v);
                rand_side();
                if ($urandom_range(0, 99) == 0) ram_ofs = 4'($urandom);
                step();
            end
        end
        bus.pal_we = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
